// File: rtl/shift_pipe_ctrl_if.sv
// Issue-side and writeback-side valid/ready bundle for shift_pipe_ctrl.
// master drives operations and accepts results; slave is the pipeline.
interface shift_pipe_ctrl_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_op;
    logic [SHW-1:0]   in_shamt;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    modport master (
        output in_valid, in_op, in_shamt, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_op, in_shamt, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/shift_pipe_ctrl.sv
// Two-stage valid/ready wrapper around the one-hot-controlled left-shift core (SLL/SRL/SRA).
// Define SHIFT_SRA_EN to make op 11 an arithmetic right shift with sign fill; otherwise it is SRL.
module shift_pipe_ctrl #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    shift_pipe_ctrl_if.slave bus,
    output logic [WIDTH-1:0] core_shift,
    output logic [WIDTH-1:0] core_datain,
    input  logic [WIDTH-1:0] core_dataout
);
    typedef enum logic [1:0] {
        OpSll  = 2'b00,
        OpSrl  = 2'b01,
        OpPass = 2'b10,
        OpSra  = 2'b11
    } op_e;

    localparam logic [WIDTH-1:0] One  = WIDTH'(1);
    localparam logic [WIDTH-1:0] Ones = {WIDTH{1'b1}};

    // Right shifts reuse the left-shift core by reversing bits on the way in and out.
    function automatic logic [WIDTH-1:0] bitrev(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        for (int i = 0; i < WIDTH; i++) begin
            r[i] = v[WIDTH-1-i];
        end
        return r;
    endfunction

    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] core_shift_q, core_shift_d;
    logic [WIDTH-1:0] core_datain_q, core_datain_d;
    logic             s1_right_q, s1_right_d;
`ifdef SHIFT_SRA_EN
    logic             s1_fill_q, s1_fill_d;
    logic [WIDTH-1:0] s1_mask_q, s1_mask_d;
`endif
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;

    logic             s2_adv;
    logic             s1_adv;
    logic             in_ready;
    logic             accept;
    logic             in_right;
    logic [SHW-1:0]   shamt;
    op_e              op;
    logic [WIDTH-1:0] s2_rev;
    logic [WIDTH-1:0] s2_res;

    assign shamt = bus.in_shamt;
    assign op    = op_e'(bus.in_op);

    // in_ready combinationally follows out_ready so a full pipe can refill without a bubble.
    always_comb begin
        s2_adv   = ~out_valid_q | bus.out_ready;
        s1_adv   = s2_adv;
        in_ready = ~flush & (~s1_valid_q | s1_adv);
        accept   = bus.in_valid & in_ready;
        in_right = (op == OpSrl) | (op == OpSra);
    end

    always_comb begin
        s1_valid_d    = s1_valid_q;
        core_shift_d  = core_shift_q;
        core_datain_d = core_datain_q;
        s1_right_d    = s1_right_q;
`ifdef SHIFT_SRA_EN
        s1_fill_d     = s1_fill_q;
        s1_mask_d     = s1_mask_q;
`endif
        if (flush) begin
            s1_valid_d = 1'b0;
        end else if (accept) begin
            s1_valid_d    = 1'b1;
            core_shift_d  = (op == OpPass) ? One : (One << shamt);
            core_datain_d = in_right ? bitrev(bus.in_data) : bus.in_data;
            s1_right_d    = in_right;
`ifdef SHIFT_SRA_EN
            s1_fill_d     = (op == OpSra) & bus.in_data[WIDTH-1];
            s1_mask_d     = ~(Ones >> shamt);
`endif
        end else if (s1_adv) begin
            s1_valid_d = 1'b0;
        end
    end

    always_comb begin
        s2_rev = s1_right_q ? bitrev(core_dataout) : core_dataout;
`ifdef SHIFT_SRA_EN
        s2_res = s2_rev | (s1_fill_q ? s1_mask_q : '0);
`else
        s2_res = s2_rev;
`endif
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (s2_adv) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_data_d = s2_res;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q    <= 1'b0;
            core_shift_q  <= '0;
            core_datain_q <= '0;
            s1_right_q    <= 1'b0;
`ifdef SHIFT_SRA_EN
            s1_fill_q     <= 1'b0;
            s1_mask_q     <= '0;
`endif
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
        end else begin
            s1_valid_q    <= s1_valid_d;
            core_shift_q  <= core_shift_d;
            core_datain_q <= core_datain_d;
            s1_right_q    <= s1_right_d;
`ifdef SHIFT_SRA_EN
            s1_fill_q     <= s1_fill_d;
            s1_mask_q     <= s1_mask_d;
`endif
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign core_shift    = core_shift_q;
    assign core_datain   = core_datain_q;
endmodule

// File: tb/tb_shift_pipe_ctrl.sv
// Scoreboard bench for shift_pipe_ctrl with a behavioural one-hot left-shift core.
// Honours SHIFT_SRA_EN the same way the design does.
module tb_shift_pipe_ctrl;
    logic        clk;
    logic        rst;
    logic        flush;
    logic [31:0] core_shift;
    logic [31:0] core_datain;
    logic [31:0] core_dataout;

    int n_tests = 0;
    int n_fail  = 0;
    int n_dlv   = 0;
    logic [31:0] exp_q[$];

    shift_pipe_ctrl_if #(.WIDTH(32), .SHW(5)) bus ();

    shift_pipe_ctrl #(.WIDTH(32), .SHW(5)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .bus          (bus),
        .core_shift   (core_shift),
        .core_datain  (core_datain),
        .core_dataout (core_dataout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        core_dataout = '0;
        for (int i = 0; i < 32; i++) begin
            if (core_shift[i]) core_dataout = core_datain << i;
        end
    end

    function automatic logic [31:0] model(input logic [1:0] op, input logic [4:0] sh,
                                          input logic [31:0] d);
        case (op)
            2'b00:   return d << sh;
            2'b01:   return d >> sh;
`ifdef SHIFT_SRA_EN
            2'b11:   return $unsigned($signed(d) >>> sh);
`else
            2'b11:   return d >> sh;
`endif
            default: return d;
        endcase
    endfunction

    task automatic drive(input logic v, input logic [1:0] op, input logic [4:0] sh,
                         input logic [31:0] d);
        bus.in_valid = v;
        bus.in_op    = op;
        bus.in_shamt = sh;
        bus.in_data  = d;
    endtask

    // Called at a negedge with inputs set; samples both handshakes just before the next posedge.
    task automatic tick();
        logic        acc;
        logic        dlv;
        logic [31:0] e;
        #2;
        acc = bus.in_valid & bus.in_ready;
        dlv = bus.out_valid & bus.out_ready;
        if (dlv) begin
            n_tests++;
            n_dlv++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected: got %h, required no output", bus.out_data);
            end else begin
                e = exp_q.pop_front();
                if (bus.out_data !== e) begin
                    n_fail++;
                    $display("FAIL sb_data: got %h, required %h", bus.out_data, e);
                end
            end
        end
        if (flush) exp_q.delete();
        if (acc) exp_q.push_back(model(bus.in_op, bus.in_shamt, bus.in_data));
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        flush = 1'b0;
        bus.out_ready = 1'b1;
        drive(1'b0, 2'b00, 5'd0, 32'h0);
        repeat (2) @(negedge clk);
        n_tests++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== 32'h0 || core_shift !== 32'h0 ||
            core_datain !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_state: got v=%b d=%h sh=%h di=%h, required all 0",
                     bus.out_valid, bus.out_data, core_shift, core_datain);
        end
        rst = 1'b0;
        #1;
        n_tests++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b, required 1", bus.in_ready);
        end
        flush = 1'b1;
        #1;
        n_tests++;
        if (bus.in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_in_ready: got %b, required 0", bus.in_ready);
        end
        flush = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_sll();
        bus.out_ready = 1'b1;
        drive(1'b1, 2'b00, 5'd4, 32'h0000_00F1);
        tick();
        drive(1'b0, 2'b00, 5'd0, 32'h0);
        #1;
        n_tests++;
        if (bus.out_valid !== 1'b0 || core_shift !== 32'h10 || core_datain !== 32'hF1) begin
            n_fail++;
            $display("FAIL sll_stage1: got v=%b sh=%h di=%h, required v=0 sh=00000010 di=000000f1",
                     bus.out_valid, core_shift, core_datain);
        end
        tick();
        #1;
        n_tests++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h0000_0F10) begin
            n_fail++;
            $display("FAIL sll_latency: got v=%b d=%h, required v=1 d=00000f10",
                     bus.out_valid, bus.out_data);
        end
        tick();
    endtask

    task automatic test_srl_sra();
        logic [31:0] sra_exp;
`ifdef SHIFT_SRA_EN
        sra_exp = 32'hF800_0000;
`else
        sra_exp = 32'h0800_0000;
`endif
        bus.out_ready = 1'b1;
        drive(1'b1, 2'b01, 5'd31, 32'h8000_0001);
        tick();
        drive(1'b1, 2'b11, 5'd4, 32'h8000_0000);
        tick();
        drive(1'b0, 2'b00, 5'd0, 32'h0);
        #1;
        n_tests++;
        if (bus.out_data !== 32'h0000_0001) begin
            n_fail++;
            $display("FAIL srl_31: got %h, required 00000001", bus.out_data);
        end
        tick();
        #1;
        n_tests++;
        if (bus.out_data !== sra_exp) begin
            n_fail++;
            $display("FAIL sra_4: got %h, required %h", bus.out_data, sra_exp);
        end
        tick();
    endtask

    task automatic test_pass_and_bounds();
        bus.out_ready = 1'b1;
        drive(1'b1, 2'b10, 5'd17, 32'hDEAD_BEEF);
        tick();
        drive(1'b1, 2'b11, 5'd31, 32'h8000_0000);
        tick();
        for (int op = 0; op < 4; op++) begin
            drive(1'b1, 2'(op), 5'd0, $urandom);
            tick();
        end
        drive(1'b0, 2'b00, 5'd0, 32'h0);
        repeat (2) tick();
    endtask

    task automatic test_back_to_back();
        int d0;
        d0 = n_dlv;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i < 8) drive(1'b1, 2'($urandom_range(0, 3)), 5'($urandom), $urandom);
            else drive(1'b0, 2'b00, 5'd0, 32'h0);
            #1;
            if (i < 8) begin
                n_tests++;
                if (bus.in_ready !== 1'b1) begin
                    n_fail++;
                    $display("FAIL b2b_in_ready[%0d]: got %b, required 1", i, bus.in_ready);
                end
            end
            if (i >= 2) begin
                n_tests++;
                if (bus.out_valid !== 1'b1) begin
                    n_fail++;
                    $display("FAIL b2b_out_valid[%0d]: got %b, required 1", i, bus.out_valid);
                end
            end
            tick();
        end
        n_tests++;
        if (n_dlv - d0 !== 8) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d, required 8", n_dlv - d0);
        end
    endtask

    task automatic test_stall();
        logic [31:0] a_exp;
        a_exp = model(2'b00, 5'd8, 32'h0000_1234);
        bus.out_ready = 1'b0;
        drive(1'b1, 2'b00, 5'd8, 32'h0000_1234);
        tick();
        drive(1'b1, 2'b01, 5'd3, 32'hF000_0000);
        tick();
        drive(1'b1, 2'b11, 5'd1, 32'h8000_0010);
        for (int i = 0; i < 5; i++) begin
            #1;
            n_tests++;
            if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_data !== a_exp) begin
                n_fail++;
                $display("FAIL stall[%0d]: got rdy=%b v=%b d=%h, required rdy=0 v=1 d=%h",
                         i, bus.in_ready, bus.out_valid, bus.out_data, a_exp);
            end
            tick();
        end
        bus.out_ready = 1'b1;
        #1;
        n_tests++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_release_ready: got %b, required 1", bus.in_ready);
        end
        tick();
        drive(1'b0, 2'b00, 5'd0, 32'h0);
        for (int i = 0; i < 2; i++) begin
            #1;
            n_tests++;
            if (bus.out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL stall_no_bubble[%0d]: got %b, required 1", i, bus.out_valid);
            end
            tick();
        end
        tick();
    endtask

    task automatic test_flush();
        bus.out_ready = 1'b0;
        drive(1'b1, 2'b00, 5'd1, 32'h1111_1111);
        tick();
        drive(1'b1, 2'b01, 5'd2, 32'h2222_2222);
        tick();
        drive(1'b1, 2'b00, 5'd3, 32'h3333_3333);
        flush = 1'b1;
        #1;
        n_tests++;
        if (bus.in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_blocks_accept: got %b, required 0", bus.in_ready);
        end
        tick();
        flush = 1'b0;
        drive(1'b0, 2'b00, 5'd0, 32'h0);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_tests++;
            if (bus.out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL flush_out_valid[%0d]: got %b, required 0", i, bus.out_valid);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid_stall();
        bus.out_ready = 1'b0;
        drive(1'b1, 2'b00, 5'd5, 32'h0000_00AB);
        tick();
        drive(1'b1, 2'b01, 5'd5, 32'hAB00_0000);
        tick();
        drive(1'b0, 2'b00, 5'd0, 32'h0);
        #1;
        rst = 1'b1;
        #1;
        n_tests++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== 32'h0 || core_shift !== 32'h0 ||
            core_datain !== 32'h0) begin
            n_fail++;
            $display("FAIL async_reset: got v=%b d=%h sh=%h di=%h, required all 0",
                     bus.out_valid, bus.out_data, core_shift, core_datain);
        end
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        n_tests++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset: got rdy=%b v=%b, required rdy=1 v=0",
                     bus.in_ready, bus.out_valid);
        end
        @(negedge clk);
        drive(1'b1, 2'b00, 5'd1, 32'h0000_0003);
        tick();
        drive(1'b0, 2'b00, 5'd0, 32'h0);
        repeat (2) tick();
    endtask

    initial begin
        test_reset();
        test_sll();
        test_srl_sra();
        test_pass_and_bounds();
        test_back_to_back();
        test_stall();
        test_flush();
        test_reset_mid_stall();
        repeat (3) tick();
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending results, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/shift_pipe_ctrl.md
# shift_pipe_ctrl

Two-stage pipelined front/back end around the team's 32-bit one-hot-controlled left-shift core. The block accepts RISC-V shift operations (SLL/SRL/SRA) on a valid/ready interface from the ALU issue logic. Stage 1 registers the decoded one-hot shift vector and direction-conditioned operand that feed the core. Stage 2 registers the core result after reversal and sign fill, and presents it to writeback on a valid/ready interface.

## Interface
- `WIDTH`, 32: datapath width; fixed at 32, since the core is 32-bit.
- `SHW`, 5: shift-amount width, log2(WIDTH).

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `flush`  in  1  synchronous pipeline kill.
- `in_valid`  in  1  operation offered.
- `in_ready`  out  1  operation accepted when `in_valid & in_ready`.
- `in_op`  in  2  00=SLL, 01=SRL, 11=SRA, 10=pass-through.
- `in_shamt`  in  5  shift amount 0..31.
- `in_data`  in  32  operand.
- `core_shift`  out  32  one-hot shift vector to core (registered, stage 1).
- `core_datain`  out  32  operand to core (registered, stage 1).
- `core_dataout`  in  32  combinational core result, left-shifted.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  writeback accepts.
- `out_data`  out  32  shifted result.

## Operation
- Stage 1 captures on `in_valid & in_ready`. It registers:
  - `core_shift = 1 << in_shamt`.
  - `core_datain = right ? bitrev(in_data) : in_data`, where right = (op==01 | op==11).
  - s1_right.
  - s1_fill = (op==11) & in_data[31].
  - s1_mask = ~(32'hFFFF_FFFF >> in_shamt).
- Pass-through (op 10): shift vector is forced to 32'h1 and right=0, so `out_data = in_data`.
- Stage 2 captures when stage 1 advances:
  - r = s1_right ? bitrev(core_dataout) : core_dataout.
  - `out_data = r | (s1_fill ? s1_mask : 0)`.
- Handshake:
  - s2_adv = ~out_valid | out_ready.
  - s1_adv = s2_adv.
  - `in_ready = ~s1_valid | s1_adv`.
  - `in_ready` depends combinationally on `out_ready`; this is an accepted path.
- `out_valid`/`out_data` hold stable while `out_valid & ~out_ready`.
- `flush`:
  - Clears s1_valid and `out_valid` at the next edge.
  - A handshake offered in the same cycle is not accepted: `in_ready` is forced 0 while `flush` is high.
  - Flush takes priority over every advance.
- Reset (async, any cycle, including mid-stall):
  - s1_valid=0, `out_valid`=0.
  - `core_shift`=0, `core_datain`=0, `out_data`=0.
  - `in_ready` reads 1 after reset deasserts, unless `flush` is high.

## Timing
- Latency: accept at edge N gives `out_valid`=1 after edge N+1 when unstalled (two register stages).
- Throughput: 1 op/cycle with `out_ready` held 1.
- Full stall (both stages valid, `out_ready`=0): `in_ready`=0, and neither stage updates.
- Simultaneous `out_ready` and a new accept while full: both stages advance in the same edge, with no bubble.
- Shift by 0: output equals input for all ops.
- SRA by 31 of a negative operand gives 32'hFFFF_FFFF.

## Configuration
- `SHIFT_SRA_EN` defined: op 11 performs arithmetic right shift with sign fill as above.
- Undefined:
  - s1_fill is tied 0, and op 11 behaves exactly as SRL.
  - Mask register and fill logic are removed.

## Test plan
- SLL, data=32'h0000_00F1, shamt=4, `out_ready`=1 -> `out_data`=32'h0000_0F10, `out_valid` one cycle after accept edge.
- SRL 32'h8000_0001 by 31 -> 32'h0000_0001; SRA 32'h8000_0000 by 4 -> 32'hF800_0000 (with `SHIFT_SRA_EN`), 32'h0800_0000 without.
- Back-to-back stream of 8 ops, `out_ready`=1 -> 8 results on 8 consecutive cycles, in order, `in_ready` constantly 1.
- Fill both stages, hold `out_ready`=0 for 5 cycles -> `in_ready`=0, `out_data` stable; then raise `out_ready` with a new op -> no bubble, order preserved.
- `flush` with both stages valid -> both valids 0 next cycle, the flushed ops never appear; async `rst` pulse mid-stall -> all outputs 0 immediately.
- op 10 pass-through, data 32'hDEAD_BEEF, shamt=17 -> 32'hDEAD_BEEF.
